// File: rtl/if_prefetch_stage.sv
// Instruction-fetch prefetch stage: owns the fetch PC, looks up I-cache and
// BTB combinationally, issues one outstanding memory read on a miss, refills
// the cache, and queues {inst, pc, prediction} entries for ID.
//
// Ports:
//   clk, rst (async, active-low)
//   flush, flush_pc                      redirect from EX
//   cache_addr/cache_hit/cache_val       I-cache lookup
//   fill_en/fill_addr/fill_data          cache refill strobe (mem_done cycle)
//   mem_req/mem_addr/mem_done/mem_data   single-outstanding memory read
//   btb_addr/btb_hit/btb_target          branch target buffer lookup
//   id_valid/id_ready/id_inst/id_pc/id_pred_taken/id_pred_target  queue head
module if_prefetch_stage #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic [ADDR_W-1:0] cache_addr,
  input  logic              cache_hit,
  input  logic [INST_W-1:0] cache_val,
  output logic              fill_en,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [INST_W-1:0] fill_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_done,
  input  logic [INST_W-1:0] mem_data,
  output logic [ADDR_W-1:0] btb_addr,
  input  logic              btb_hit,
  input  logic [ADDR_W-1:0] btb_target,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [INST_W-1:0] id_inst,
  output logic [ADDR_W-1:0] id_pc,
  output logic              id_pred_taken,
  output logic [ADDR_W-1:0] id_pred_target
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    MISS  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [ADDR_W-1:0] req_target_q, req_target_d;
  logic              req_taken_q, req_taken_d;
  logic              reserved_q, reserved_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [INST_W-1:0] q_inst_q   [DEPTH];
  logic [ADDR_W-1:0] q_pc_q     [DEPTH];
  logic              q_taken_q  [DEPTH];
  logic [ADDR_W-1:0] q_target_q [DEPTH];

  logic              push_en, pop_en, fill_c, room;
  logic [INST_W-1:0] push_inst;
  logic [ADDR_W-1:0] push_pc, push_target, npred;
  logic              push_taken;

  // Next-state, queue control and refill decode
  always_comb begin
    npred        = btb_hit ? btb_target : pc_q + ADDR_W'(4);
    // Reservation for an in-flight miss counts as occupied so its push always fits
    room         = (count_q + CNT_W'(reserved_q)) < CNT_W'(DEPTH);
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    req_taken_d  = req_taken_q;
    req_target_d = req_target_q;
    reserved_d   = reserved_q;
    push_en      = 1'b0;
    push_inst    = cache_val;
    push_pc      = pc_q;
    push_taken   = btb_hit;
    push_target  = npred;
    pop_en       = id_valid && id_ready;
    fill_c       = 1'b0;

    case (state_q)
      FETCH: begin
        if (flush) begin
          pc_d = flush_pc;
        end else if (room) begin
          if (cache_hit) begin
            push_en = 1'b1;
            pc_d    = npred;
          end else begin
            req_pc_d     = pc_q;
            req_taken_d  = btb_hit;
            req_target_d = npred;
            reserved_d   = 1'b1;
            state_d      = MISS;
          end
        end
      end
      MISS: begin
        push_inst   = mem_data;
        push_pc     = req_pc_q;
        push_taken  = req_taken_q;
        push_target = req_target_q;
        if (mem_done) begin
          fill_c     = 1'b1;
          reserved_d = 1'b0;
          state_d    = FETCH;
          if (!flush) begin
            push_en = 1'b1;
            pc_d    = req_target_q;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
        if (flush) pc_d = flush_pc;
      end
      DRAIN: begin
        // Request cannot be cancelled; the word still refills the cache
        if (mem_done) begin
          fill_c  = 1'b1;
          state_d = FETCH;
        end
        if (flush) pc_d = flush_pc;
      end
      default: state_d = FETCH;
    endcase

    // Flush wins over any same-cycle queue activity
    if (flush) begin
      push_en    = 1'b0;
      pop_en     = 1'b0;
      reserved_d = 1'b0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      head_d  = head_q + PTR_W'(pop_en);
      tail_d  = tail_q + PTR_W'(push_en);
      count_d = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      req_taken_q  <= 1'b0;
      req_target_q <= '0;
      reserved_q   <= 1'b0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      req_taken_q  <= req_taken_d;
      req_target_q <= req_target_d;
      reserved_q   <= reserved_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
    end
  end

  // Queue storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_inst_q[i]   <= '0;
        q_pc_q[i]     <= '0;
        q_taken_q[i]  <= 1'b0;
        q_target_q[i] <= '0;
      end
    end else if (push_en) begin
      q_inst_q[tail_q]   <= push_inst;
      q_pc_q[tail_q]     <= push_pc;
      q_taken_q[tail_q]  <= push_taken;
      q_target_q[tail_q] <= push_target;
    end
  end

  assign cache_addr     = pc_q;
  assign btb_addr       = pc_q;
  assign mem_req        = (state_q != FETCH);
  assign mem_addr       = mem_req ? req_pc_q : '0;
  assign fill_en        = fill_c;
  assign fill_addr      = fill_c ? req_pc_q : '0;
  assign fill_data      = fill_c ? mem_data : '0;
  assign id_valid       = (count_q != '0);
  assign id_inst        = q_inst_q[head_q];
  assign id_pc          = q_pc_q[head_q];
  assign id_pred_taken  = q_taken_q[head_q];
  assign id_pred_target = q_target_q[head_q];

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage: hit streaming, miss/refill, BTB
// prediction, backpressure, flush during miss, and reset mid-miss.
module tb_if_prefetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] cache_addr;
  logic        cache_hit;
  logic [31:0] cache_val;
  logic        fill_en;
  logic [31:0] fill_addr;
  logic [31:0] fill_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;
  logic [31:0] btb_addr;
  logic        btb_hit;
  logic [31:0] btb_target;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_pred_taken;
  logic [31:0] id_pred_target;

  // Small direct-mapped cache/BTB images covering 0x000..0xFFC
  logic        cv [1024];
  logic [31:0] cd [1024];
  logic        bv [1024];
  logic [31:0] bt [1024];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign cache_hit  = (cache_addr < 32'h1000) && cv[cache_addr[11:2]];
  assign cache_val  = cd[cache_addr[11:2]];
  assign btb_hit    = (btb_addr < 32'h1000) && bv[btb_addr[11:2]];
  assign btb_target = bt[btb_addr[11:2]];

  if_prefetch_stage #(
    .ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
    .cache_addr(cache_addr), .cache_hit(cache_hit), .cache_val(cache_val),
    .fill_en(fill_en), .fill_addr(fill_addr), .fill_data(fill_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done), .mem_data(mem_data),
    .btb_addr(btb_addr), .btb_hit(btb_hit), .btb_target(btb_target),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
    .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] hd(input logic [31:0] a);
    return 32'h1300_0000 | a;
  endfunction

  task automatic mark_hit(input logic [31:0] a);
    cv[a[11:2]] = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      cv[i] = 1'b0;
      cd[i] = 32'h1300_0000 | (32'(i) << 2);
      bv[i] = 1'b0;
      bt[i] = 32'h0;
    end
    for (int a = 0; a <= 32'hC; a += 4) mark_hit(32'(a));
    for (int a = 32'h14; a <= 32'h20; a += 4) mark_hit(32'(a));
    for (int a = 32'h100; a <= 32'h13C; a += 4) mark_hit(32'(a));
    mark_hit(32'h200);
    bv[32'h20 >> 2] = 1'b1;
    bt[32'h20 >> 2] = 32'h100;

    rst = 1'b0; flush = 1'b0; flush_pc = '0; mem_done = 1'b0; mem_data = '0; id_ready = 1'b1;
    tick(); tick();
    check_eq("rst id_valid", 32'(id_valid), 32'h0);
    check_eq("rst mem_req", 32'(mem_req), 32'h0);
    check_eq("rst fill_en", 32'(fill_en), 32'h0);
    check_eq("rst cache_addr", cache_addr, 32'h0);
    check_eq("rst id_pc", id_pc, 32'h0);
    rst = 1'b1;

    // Consecutive hits 0x0..0xC, one per cycle
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("hit id_valid", 32'(id_valid), 32'h1);
      check_eq("hit id_pc", id_pc, 32'(4 * k));
      check_eq("hit id_inst", id_inst, hd(32'(4 * k)));
      check_eq("hit id_pred_target", id_pred_target, 32'(4 * k + 4));
      check_eq("hit id_pred_taken", 32'(id_pred_taken), 32'h0);
    end
    check_eq("miss lookup addr", cache_addr, 32'h10);

    // Miss at 0x10: request held five cycles, then completion
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("miss mem_req", 32'(mem_req), 32'h1);
      check_eq("miss mem_addr", mem_addr, 32'h10);
      check_eq("miss id_valid", 32'(id_valid), 32'h0);
      check_eq("miss fill_en idle", 32'(fill_en), 32'h0);
    end
    mem_done = 1'b1; mem_data = 32'h00A0_0093;
    #1;
    check_eq("fill_en", 32'(fill_en), 32'h1);
    check_eq("fill_addr", fill_addr, 32'h10);
    check_eq("fill_data", fill_data, 32'h00A0_0093);
    tick();
    mem_done = 1'b0; mem_data = '0;
    check_eq("refill id_valid", 32'(id_valid), 32'h1);
    check_eq("refill id_inst", id_inst, 32'h00A0_0093);
    check_eq("refill id_pc", id_pc, 32'h10);
    check_eq("refill fill_en off", 32'(fill_en), 32'h0);
    check_eq("refill mem_req off", 32'(mem_req), 32'h0);
    check_eq("resume addr", cache_addr, 32'h14);

    // 0x14..0x1C hits, then BTB-predicted 0x20 -> 0x100
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("seq id_pc", id_pc, 32'(32'h14 + 4 * k));
    end
    tick();
    check_eq("btb id_pc", id_pc, 32'h20);
    check_eq("btb id_pred_taken", 32'(id_pred_taken), 32'h1);
    check_eq("btb id_pred_target", id_pred_target, 32'h100);
    check_eq("btb next lookup", cache_addr, 32'h100);

    // Backpressure: queue fills to DEPTH and fetch holds
    id_ready = 1'b0;
    tick(); tick(); tick();
    check_eq("full cache_addr", cache_addr, 32'h10C);
    tick();
    check_eq("stall cache_addr", cache_addr, 32'h10C);
    check_eq("stall id_pc", id_pc, 32'h20);
    tick();
    check_eq("stall2 cache_addr", cache_addr, 32'h10C);
    check_eq("stall2 id_valid", 32'(id_valid), 32'h1);
    check_eq("stall2 id_pc", id_pc, 32'h20);
    id_ready = 1'b1;
    tick();
    check_eq("pop-while-full id_pc", id_pc, 32'h100);
    check_eq("pop-while-full hold", cache_addr, 32'h10C);
    for (int k = 1; k < 4; k++) begin
      tick();
      check_eq("drain id_valid", 32'(id_valid), 32'h1);
      check_eq("drain id_pc", id_pc, 32'(32'h100 + 4 * k));
    end

    // Flush to 0x40 (miss), then flush to 0x200 while the miss is in flight
    flush = 1'b1; flush_pc = 32'h40;
    tick();
    flush = 1'b0;
    check_eq("flush id_valid", 32'(id_valid), 32'h0);
    check_eq("flush cache_addr", cache_addr, 32'h40);
    tick();
    check_eq("miss40 mem_req", 32'(mem_req), 32'h1);
    check_eq("miss40 mem_addr", mem_addr, 32'h40);
    flush = 1'b1; flush_pc = 32'h200;
    tick();
    flush = 1'b0;
    check_eq("drain mem_req", 32'(mem_req), 32'h1);
    check_eq("drain mem_addr", mem_addr, 32'h40);
    check_eq("drain q empty", 32'(id_valid), 32'h0);
    tick();
    check_eq("drain2 mem_req", 32'(mem_req), 32'h1);
    mem_done = 1'b1; mem_data = 32'hDEAD_BEEF;
    #1;
    check_eq("drain fill_en", 32'(fill_en), 32'h1);
    check_eq("drain fill_addr", fill_addr, 32'h40);
    check_eq("drain fill_data", fill_data, 32'hDEAD_BEEF);
    tick();
    mem_done = 1'b0; mem_data = '0;
    check_eq("post-drain id_valid", 32'(id_valid), 32'h0);
    check_eq("post-drain mem_req", 32'(mem_req), 32'h0);
    check_eq("post-drain lookup", cache_addr, 32'h200);
    tick();
    check_eq("redirect id_valid", 32'(id_valid), 32'h1);
    check_eq("redirect id_pc", id_pc, 32'h200);
    check_eq("redirect id_inst", id_inst, hd(32'h200));

    // Reset asserted while a miss at 0x204 is outstanding
    tick();
    check_eq("miss204 mem_req", 32'(mem_req), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("async rst mem_req", 32'(mem_req), 32'h0);
    check_eq("async rst mem_addr", mem_addr, 32'h0);
    check_eq("async rst id_valid", 32'(id_valid), 32'h0);
    check_eq("async rst fill_en", 32'(fill_en), 32'h0);
    check_eq("async rst cache_addr", cache_addr, 32'h0);
    check_eq("async rst id_pc", id_pc, 32'h0);
    tick();
    rst = 1'b1;
    check_eq("post-rst cache_addr", cache_addr, 32'h0);
    tick();
    check_eq("post-rst mem_req", 32'(mem_req), 32'h0);
    check_eq("post-rst id_pc", id_pc, 32'h0);
    check_eq("post-rst id_valid", 32'(id_valid), 32'h1);
    check_eq("post-rst next addr", cache_addr, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
